seq_mult_ctrl: RTL and testbench



---
 rtl/seq_mult_ctrl.sv | 96 +++++++++
 tb/tb_seq_mult_ctrl.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_mult_ctrl.sv
// Control FSM for the sequential 8x8 multiplier: sequences operand load, four
// nibble partial products and the accumulator, with a start/busy/done/ack handshake.
module seq_mult_ctrl #(
  parameter bit AUTO_ACK = 1'b0
) (
  input  logic       clk,
  input  logic       aclr_n,
  input  logic       start,
  input  logic       ack,
  output logic       busy,
  output logic       done,
  output logic [1:0] count,
  output logic [1:0] input_sel,
  output logic [1:0] shift_sel,
  output logic       op_load,
  output logic       acc_clr,
  output logic       acc_en,
  output logic       err
);

  typedef enum logic [1:0] {IDLE, LOAD, CALC, DONE} state_t;

  state_t     state, state_nx;
  logic [1:0] count_nx;
  logic       err_nx;
  logic [1:0] shift_nx;

  always_comb begin
    state_nx = IDLE;
    count_nx = '0;
    err_nx   = err;
    case (state)
      IDLE: begin
        if (start) begin
          state_nx = LOAD;
          err_nx   = 1'b0;
        end
      end
      LOAD: begin
        state_nx = CALC;
        err_nx   = err | start;
      end
      CALC: begin
        err_nx = err | start;
        if (count == 2'd3) begin
          state_nx = DONE;
        end else begin
          state_nx = CALC;
          count_nx = count + 2'd1;
        end
      end
      DONE: begin
        err_nx   = err | start;
        state_nx = (AUTO_ACK || ack) ? IDLE : DONE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Middle partial products (a_lo*b_hi, a_hi*b_lo) share the <<4 weight.
  always_comb begin
    case (count_nx)
      2'd0:    shift_nx = 2'b00;
      2'd3:    shift_nx = 2'b10;
      default: shift_nx = 2'b01;
    endcase
  end

  // Outputs are registered from the next-state decode so they track state exactly.
  always_ff @(posedge clk) begin
    if (!aclr_n) begin
      state     <= IDLE;
      count     <= '0;
      err       <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      op_load   <= 1'b0;
      acc_clr   <= 1'b0;
      acc_en    <= 1'b0;
      input_sel <= '0;
      shift_sel <= '0;
    end else begin
      state     <= state_nx;
      count     <= count_nx;
      err       <= err_nx;
      busy      <= (state_nx == LOAD) || (state_nx == CALC);
      done      <= (state_nx == DONE);
      op_load   <= (state_nx == LOAD);
      acc_clr   <= (state_nx == LOAD);
      acc_en    <= (state_nx == CALC);
      input_sel <= (state_nx == CALC) ? count_nx : 2'b00;
      shift_sel <= (state_nx == CALC) ? shift_nx : 2'b00;
    end
  end

endmodule

// File: tb/tb_seq_mult_ctrl.sv
// Bench for seq_mult_ctrl: two instances (AUTO_ACK=0 and 1) checked against a
// cycles-since-start reference model and an attached multiplier datapath model.
module tb_seq_mult_ctrl;

  logic       clk = 1'b0;
  logic       aclr_n;
  logic       start_i[2];
  logic       ack_i[2];
  logic [7:0] a_in[2];
  logic [7:0] b_in[2];

  logic       busy_o[2], done_o[2], op_load_o[2], acc_clr_o[2], acc_en_o[2], err_o[2];
  logic [1:0] count_o[2], input_sel_o[2], shift_sel_o[2];
  logic [12:0] obs[2];

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  seq_mult_ctrl #(.AUTO_ACK(1'b0)) u0 (
    .clk(clk), .aclr_n(aclr_n), .start(start_i[0]), .ack(ack_i[0]),
    .busy(busy_o[0]), .done(done_o[0]), .count(count_o[0]),
    .input_sel(input_sel_o[0]), .shift_sel(shift_sel_o[0]),
    .op_load(op_load_o[0]), .acc_clr(acc_clr_o[0]), .acc_en(acc_en_o[0]), .err(err_o[0])
  );

  seq_mult_ctrl #(.AUTO_ACK(1'b1)) u1 (
    .clk(clk), .aclr_n(aclr_n), .start(start_i[1]), .ack(ack_i[1]),
    .busy(busy_o[1]), .done(done_o[1]), .count(count_o[1]),
    .input_sel(input_sel_o[1]), .shift_sel(shift_sel_o[1]),
    .op_load(op_load_o[1]), .acc_clr(acc_clr_o[1]), .acc_en(acc_en_o[1]), .err(err_o[1])
  );

  assign obs[0] = {busy_o[0], done_o[0], count_o[0], input_sel_o[0], shift_sel_o[0],
                   op_load_o[0], acc_clr_o[0], acc_en_o[0], err_o[0]};
  assign obs[1] = {busy_o[1], done_o[1], count_o[1], input_sel_o[1], shift_sel_o[1],
                   op_load_o[1], acc_clr_o[1], acc_en_o[1], err_o[1]};

  // Reference model: mk = cycles since the accepted start (0 idle, 1 load,
  // 2..5 the four partial-product steps, 6 result available).
  int         mk[2]    = '{0, 0};
  logic       merr[2]  = '{1'b0, 1'b0};
  logic [15:0] mprod[2];

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!aclr_n) begin
        mk[i]   <= 0;
        merr[i] <= 1'b0;
      end else if (mk[i] == 0) begin
        if (start_i[i]) begin
          mk[i]   <= 1;
          merr[i] <= 1'b0;
        end
      end else begin
        if (start_i[i]) merr[i] <= 1'b1;
        if (mk[i] == 1) mprod[i] <= 16'(a_in[i]) * 16'(b_in[i]);
        if (mk[i] < 6) mk[i] <= mk[i] + 1;
        else if (i == 1 || ack_i[i]) mk[i] <= 0;
      end
    end
  end

  function automatic logic [12:0] exp_vec(input int k, input logic e);
    logic       calc;
    int         step, sh;
    logic [1:0] st2, ss;
    calc = (k >= 2 && k <= 5);
    step = calc ? k - 2 : 0;
    sh   = (!calc || step == 0) ? 0 : (step == 3) ? 8 : 4;
    st2  = 2'(step);
    ss   = 2'(sh / 4);
    return {(k >= 1 && k <= 5), (k == 6), st2, st2, ss, (k == 1), (k == 1), calc, e};
  endfunction

  // Datapath driven by the DUT's own control outputs.
  logic [7:0]  ra[2], rb[2];
  logic [15:0] acc[2];

  function automatic logic [15:0] partial(input logic [7:0] a, input logic [7:0] b,
                                          input logic [1:0] isel, input logic [1:0] ssel);
    logic [3:0] na, nb;
    na = isel[1] ? a[7:4] : a[3:0];
    nb = isel[0] ? b[7:4] : b[3:0];
    return (16'(na) * 16'(nb)) << (4 * int'(ssel));
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (op_load_o[i]) begin
        ra[i] <= a_in[i];
        rb[i] <= b_in[i];
      end
      if (acc_clr_o[i]) acc[i] <= '0;
      else if (acc_en_o[i]) acc[i] <= acc[i] + partial(ra[i], rb[i], input_sel_o[i], shift_sel_o[i]);
    end
  end

  task automatic test_reset();
    aclr_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (obs[i] !== 13'b0) begin
        fails++;
        $display("FAIL reset_u%0d: got %b want %b", i, obs[i], 13'b0);
      end
    end
    aclr_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (obs[i] !== exp_vec(mk[i], merr[i])) begin
        fails++;
        $display("FAIL reset_idle_u%0d: got %b want %b", i, obs[i], exp_vec(mk[i], merr[i]));
      end
    end
  endtask

  task automatic test_single(input logic [7:0] a, input logic [7:0] b, input int hold);
    logic [15:0] p;
    p = 16'(a) * 16'(b);
    a_in[0] = a;
    b_in[0] = b;
    start_i[0] = 1'b1;
    @(negedge clk);
    start_i[0] = 1'b0;
    for (int c = 1; c <= 6 + hold; c++) begin
      checks++;
      if (obs[0] !== exp_vec(mk[0], merr[0])) begin
        fails++;
        $display("FAIL single_c%0d: got %b want %b", c, obs[0], exp_vec(mk[0], merr[0]));
      end
      if (c >= 6) begin
        checks++;
        if (acc[0] !== p || done_o[0] !== 1'b1) begin
          fails++;
          $display("FAIL single_product_c%0d: got %h done=%b want %h done=1", c, acc[0], done_o[0], p);
        end
      end
      @(negedge clk);
    end
    ack_i[0] = 1'b1;
    @(negedge clk);
    ack_i[0] = 1'b0;
    checks++;
    if (obs[0] !== exp_vec(mk[0], merr[0]) || done_o[0] !== 1'b0) begin
      fails++;
      $display("FAIL single_ack: got %b want %b", obs[0], exp_vec(mk[0], merr[0]));
    end
  endtask

  task automatic test_auto_back_to_back();
    int last_load = -1;
    int run = 0;
    start_i[1] = 1'b1;
    for (int c = 0; c < 45; c++) begin
      a_in[1] = 8'($urandom);
      b_in[1] = 8'($urandom);
      @(negedge clk);
      checks++;
      if (obs[1] !== exp_vec(mk[1], merr[1])) begin
        fails++;
        $display("FAIL auto_c%0d: got %b want %b", c, obs[1], exp_vec(mk[1], merr[1]));
      end
      if (op_load_o[1]) begin
        if (last_load >= 0) begin
          checks++;
          if (c - last_load != 7) begin
            fails++;
            $display("FAIL auto_period: got %0d want 7", c - last_load);
          end
        end
        last_load = c;
      end
      if (done_o[1]) begin
        run++;
        checks++;
        if (acc[1] !== mprod[1]) begin
          fails++;
          $display("FAIL auto_product: got %h want %h", acc[1], mprod[1]);
        end
      end else if (run != 0) begin
        checks++;
        if (run != 1) begin
          fails++;
          $display("FAIL auto_done_width: got %0d want 1", run);
        end
        run = 0;
      end
    end
    start_i[1] = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_start_in_calc();
    int cyc = 0;
    a_in[0] = 8'($urandom);
    b_in[0] = 8'($urandom);
    start_i[0] = 1'b1;
    @(negedge clk);
    start_i[0] = 1'b0;
    cyc = 1;
    while (done_o[0] !== 1'b1 && cyc < 12) begin
      checks++;
      if (obs[0] !== exp_vec(mk[0], merr[0])) begin
        fails++;
        $display("FAIL calc_start_c%0d: got %b want %b", cyc, obs[0], exp_vec(mk[0], merr[0]));
      end
      start_i[0] = (count_o[0] == 2'd2 && acc_en_o[0] === 1'b1);
      @(negedge clk);
      start_i[0] = 1'b0;
      cyc++;
    end
    checks++;
    if (cyc != 6 || err_o[0] !== 1'b1 || acc[0] !== mprod[0]) begin
      fails++;
      $display("FAIL calc_start_done: got cyc=%0d err=%b acc=%h want cyc=6 err=1 acc=%h",
               cyc, err_o[0], acc[0], mprod[0]);
    end
    ack_i[0] = 1'b1;
    @(negedge clk);
    ack_i[0] = 1'b0;
    @(negedge clk);
    checks++;
    if (err_o[0] !== 1'b1 || busy_o[0] !== 1'b0) begin
      fails++;
      $display("FAIL calc_start_err_sticky: got err=%b busy=%b want err=1 busy=0", err_o[0], busy_o[0]);
    end
    test_single(8'($urandom), 8'($urandom), 0);
    checks++;
    if (err_o[0] !== 1'b0) begin
      fails++;
      $display("FAIL calc_start_err_clear: got %b want 0", err_o[0]);
    end
  endtask

  task automatic test_reset_mid_calc();
    start_i[0] = 1'b1;
    start_i[1] = 1'b1;
    @(negedge clk);
    start_i[0] = 1'b0;
    start_i[1] = 1'b0;
    repeat (2) @(negedge clk);
    aclr_n = 1'b0;
    @(negedge clk);
    aclr_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (obs[i] !== exp_vec(mk[i], merr[i]) ||
          {busy_o[i], acc_en_o[i], err_o[i], count_o[i]} !== 5'b0) begin
        fails++;
        $display("FAIL reset_mid_calc_u%0d: got %b want %b", i, obs[i], exp_vec(mk[i], merr[i]));
      end
    end
    test_single(8'($urandom), 8'($urandom), 2);
  endtask

  task automatic test_start_ack_done();
    start_i[0] = 1'b1;
    @(negedge clk);
    start_i[0] = 1'b0;
    for (int g = 0; g < 12 && done_o[0] !== 1'b1; g++) @(negedge clk);
    checks++;
    if (done_o[0] !== 1'b1 || obs[0] !== exp_vec(mk[0], merr[0])) begin
      fails++;
      $display("FAIL ack_start_reach_done: got %b want %b", obs[0], exp_vec(mk[0], merr[0]));
    end
    start_i[0] = 1'b1;
    ack_i[0]   = 1'b1;
    @(negedge clk);
    start_i[0] = 1'b0;
    ack_i[0]   = 1'b0;
    checks++;
    if (obs[0] !== exp_vec(mk[0], merr[0]) || op_load_o[0] !== 1'b0 || done_o[0] !== 1'b0 ||
        err_o[0] !== 1'b1) begin
      fails++;
      $display("FAIL ack_wins: got %b want %b", obs[0], exp_vec(mk[0], merr[0]));
    end
    test_single(8'($urandom), 8'($urandom), 0);
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 2; i++) begin
        start_i[i] = ($urandom_range(3) == 0);
        ack_i[i]   = ($urandom_range(2) == 0);
        a_in[i]    = 8'($urandom);
        b_in[i]    = 8'($urandom);
      end
      aclr_n = ($urandom_range(99) != 0);
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (obs[i] !== exp_vec(mk[i], merr[i])) begin
          fails++;
          $display("FAIL random_u%0d_c%0d: got %b want %b", i, c, obs[i], exp_vec(mk[i], merr[i]));
        end
        if (mk[i] == 6) begin
          checks++;
          if (acc[i] !== mprod[i]) begin
            fails++;
            $display("FAIL random_product_u%0d_c%0d: got %h want %h", i, c, acc[i], mprod[i]);
          end
        end
      end
    end
    aclr_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      start_i[i] = 1'b0;
      ack_i[i]   = 1'b0;
    end
  endtask

  initial begin
    aclr_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      start_i[i] = 1'b0;
      ack_i[i]   = 1'b0;
      a_in[i]    = '0;
      b_in[i]    = '0;
    end
    @(negedge clk);
    test_reset();
    test_single(8'hFF, 8'hFF, 0);
    test_single(8'h00, 8'hA5, 0);
    test_single(8'h5A, 8'hC3, 10);
    for (int n = 0; n < 3; n++) test_single(8'($urandom), 8'($urandom), n);
    test_auto_back_to_back();
    test_start_in_calc();
    test_reset_mid_calc();
    test_start_ack_done();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
